// File: rtl/decode_ctrl_stage_pkg.sv
// Shared decode definitions for the RV32I decode/control stage:
// opcodes, ALU operation codes, immediate formats and the control bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_NOP    = 7'b0000000;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_NONE     = 4'b0000;
  localparam logic [3:0] ALU_ADD      = 4'b0001;
  localparam logic [3:0] ALU_SUB      = 4'b0010;
  localparam logic [3:0] ALU_AND      = 4'b0011;
  localparam logic [3:0] ALU_OR       = 4'b0100;
  localparam logic [3:0] ALU_XOR      = 4'b0101;
  localparam logic [3:0] ALU_SLL      = 4'b0110;
  localparam logic [3:0] ALU_SRL      = 4'b0111;
  localparam logic [3:0] ALU_SRA      = 4'b1000;
  localparam logic [3:0] ALU_SLT      = 4'b1001;
  localparam logic [3:0] ALU_SLTU     = 4'b1010;
  localparam logic [3:0] ALU_PASS_IMM = 4'b1011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [3:0] alu;
    logic       is_load;
    logic       is_store;
    logic       write_en;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_bundle_t;

  // alt selects SUB/SRA; callers decide when instr[30] is meaningful.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_ctrl_stage_imm_gen.sv
// Combinational immediate generator: extracts the immediate for the given
// format and sign-extends it from instr[31] to XLEN.
module imm_gen
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I decode/control stage with valid/ready handshake,
// load-use bubble insertion, flush and a saturating stall counter.
module decode_ctrl_stage
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     imm_ext,
  output logic [ALU_OP_W-1:0] alu_opcode,
  output logic                is_load,
  output logic                is_store,
  output logic                write_en,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic                illegal,
  output logic [CNT_W-1:0]    stall_count
);

  ctrl_bundle_t    dec;
  ctrl_bundle_t    bundle_q;
  imm_fmt_e        fmt;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] imm_q;
  logic            valid_q;
  logic [CNT_W-1:0] stall_q;
  logic            rs2_used;
  logic            adv;
  logic            hazard;
  logic            capture;
  logic            stall_event;

  always_comb begin
    dec      = '0;
    fmt      = IMM_NONE;
    rs2_used = 1'b0;
    dec.rd   = instr[11:7];
    dec.rs1  = instr[19:15];
    dec.rs2  = instr[24:20];
    case (instr[6:0])
      OPC_LOAD: begin
        dec.alu      = ALU_NONE;
        dec.is_load  = 1'b1;
        dec.write_en = 1'b1;
        fmt          = IMM_I;
      end
      OPC_STORE: begin
        dec.alu      = ALU_ADD;
        dec.is_store = 1'b1;
        fmt          = IMM_S;
        rs2_used     = 1'b1;
      end
      OPC_OP: begin
        dec.alu      = alu_from_funct3(instr[14:12], instr[30]);
        dec.write_en = 1'b1;
        rs2_used     = 1'b1;
      end
      OPC_OP_IMM: begin
        // instr[30] is part of the immediate except for shift-right.
        dec.alu      = alu_from_funct3(instr[14:12],
                                       (instr[14:12] == 3'b101) && instr[30]);
        dec.write_en = 1'b1;
        fmt          = IMM_I;
      end
      OPC_BRANCH: begin
        dec.alu  = ALU_SUB;
        fmt      = IMM_B;
        rs2_used = 1'b1;
      end
      OPC_LUI: begin
        dec.alu      = ALU_PASS_IMM;
        dec.write_en = 1'b1;
        fmt          = IMM_U;
      end
      OPC_AUIPC: begin
        dec.alu      = ALU_ADD;
        dec.write_en = 1'b1;
        fmt          = IMM_U;
      end
      OPC_JAL: begin
        dec.alu      = ALU_ADD;
        dec.write_en = 1'b1;
        fmt          = IMM_J;
      end
      OPC_JALR: begin
        dec.alu      = ALU_ADD;
        dec.write_en = 1'b1;
        fmt          = IMM_I;
      end
      OPC_NOP: begin
        dec.alu = ALU_NONE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    if (dec.rd == 5'd0) dec.write_en = 1'b0;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr),
    .fmt   (fmt),
    .imm   (dec_imm)
  );

  assign adv    = !valid_q || out_ready;
  assign hazard = valid_q && bundle_q.is_load && (bundle_q.rd != 5'd0) &&
                  ((instr[19:15] == bundle_q.rd) ||
                   (rs2_used && (instr[24:20] == bundle_q.rd)));
  assign in_ready    = !rst && adv && !hazard && !flush;
  assign capture     = in_valid && in_ready;
  // A bubble only counts when a dependent instruction is actually waiting.
  assign stall_event = hazard && out_ready && in_valid && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      imm_q    <= '0;
      stall_q  <= '0;
    end else begin
      if (flush) begin
        valid_q  <= 1'b0;
        bundle_q <= '0;
        imm_q    <= '0;
      end else if (capture) begin
        valid_q  <= 1'b1;
        bundle_q <= dec;
        imm_q    <= dec_imm;
      end else if (adv) begin
        valid_q  <= 1'b0;
        bundle_q <= '0;
        imm_q    <= '0;
      end
      if (stall_event && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign out_valid   = valid_q;
  assign imm_ext     = imm_q;
  assign alu_opcode  = ALU_OP_W'(bundle_q.alu);
  assign is_load     = bundle_q.is_load;
  assign is_store    = bundle_q.is_store;
  assign write_en    = bundle_q.write_en;
  assign illegal     = bundle_q.illegal;
  assign rd          = bundle_q.rd;
  assign rs1         = bundle_q.rs1;
  assign rs2         = bundle_q.rs2;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: a cycle model built from the ISA
// decode rules is checked every cycle, plus hand-computed literal checks.
module tb_decode_ctrl_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 4;

  localparam logic [31:0] I_LW   = 32'hFFF0A283; // lw  x5,-1(x1)
  localparam logic [31:0] I_SUB  = 32'h402081B3; // sub x3,x1,x2
  localparam logic [31:0] I_ADD  = 32'h00028333; // add x6,x5,x0
  localparam logic [31:0] I_OR   = 32'h0020E3B3; // or  x7,x1,x2
  localparam logic [31:0] I_XOR  = 32'h0020C433; // xor x8,x1,x2
  localparam logic [31:0] I_SW   = 32'h0020A423; // sw  x2,8(x1)
  localparam logic [31:0] I_SW5  = 32'h00512023; // sw  x5,0(x2)
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3; // beq x1,x2,-4
  localparam logic [31:0] I_LUI  = 32'h80000537; // lui x10,0x80000
  localparam logic [31:0] I_JAL  = 32'h010000EF; // jal x1,16
  localparam logic [31:0] I_SRAI = 32'h40325213; // srai x4,x4,3
  localparam logic [31:0] I_ADDZ = 32'h00100013; // addi x0,x0,1
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic clk = 1'b0;
  logic rst, in_valid, flush, out_ready;
  logic [31:0] instr;
  logic in_ready, out_valid, is_load, is_store, write_en, illegal;
  logic [XLEN-1:0] imm_ext;
  logic [AW-1:0] alu_opcode;
  logic [4:0] rd, rs1, rs2;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  decode_ctrl_stage #(.XLEN(XLEN), .ALU_OP_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .imm_ext(imm_ext), .alu_opcode(alu_opcode), .is_load(is_load),
    .is_store(is_store), .write_en(write_en), .rd(rd), .rs1(rs1), .rs2(rs2),
    .illegal(illegal), .stall_count(stall_count)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        ld, st, we, ill;
    logic [4:0]  rd, rs1, rs2;
  } mb_t;

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
    logic [3:0] tab [8] = '{4'd1, 4'd6, 4'd9, 4'd10, 4'd5, 4'd7, 4'd4, 4'd3};
    logic [3:0] a;
    a = tab[f3];
    if (alt && (f3 == 3'd0 || f3 == 3'd5)) a = a + 4'd1;
    return a;
  endfunction

  function automatic mb_t ref_decode(input logic [31:0] w);
    mb_t r;
    r = '0;
    r.rd = w[11:7]; r.rs1 = w[19:15]; r.rs2 = w[24:20];
    case (w[6:0])
      7'h03: begin r.ld = 1; r.we = 1; r.imm = $signed(w) >>> 20; end
      7'h23: begin r.alu = 1; r.st = 1; r.imm = $signed({w[31:25], w[11:7], 20'b0}) >>> 20; end
      7'h33: begin r.alu = ref_alu(w[14:12], w[30]); r.we = 1; end
      7'h13: begin r.alu = ref_alu(w[14:12], w[30] && w[14:12] == 3'd5); r.we = 1;
                   r.imm = $signed(w) >>> 20; end
      7'h63: begin r.alu = 2;
                   r.imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0}) >>> 19; end
      7'h37: begin r.alu = 11; r.we = 1; r.imm = w & 32'hFFFF_F000; end
      7'h17: begin r.alu = 1; r.we = 1; r.imm = w & 32'hFFFF_F000; end
      7'h6F: begin r.alu = 1; r.we = 1;
                   r.imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0}) >>> 11; end
      7'h67: begin r.alu = 1; r.we = 1; r.imm = $signed(w) >>> 20; end
      7'h00: ;
      default: r.ill = 1;
    endcase
    if (r.rd == 0) r.we = 0;
    return r;
  endfunction

  // Cycle model state
  bit          m_valid = 0;
  mb_t         m_b = '0;
  int unsigned m_stall = 0;
  int unsigned m_xfer = 0;
  int unsigned d_xfer = 0;

  function automatic bit m_hazard();
    logic [6:0] op;
    bit uses_rs2;
    op = instr[6:0];
    uses_rs2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
    return m_valid && m_b.ld && m_b.rd != 0 &&
           (instr[19:15] == m_b.rd || (uses_rs2 && instr[24:20] == m_b.rd));
  endfunction

  always @(posedge clk) begin
    bit haz, adv;
    if (rst) begin
      m_valid = 0; m_b = '0; m_stall = 0;
    end else begin
      haz = m_hazard();
      adv = !m_valid || out_ready;
      if (m_valid && out_ready) m_xfer++;
      if (!flush && haz && out_ready && in_valid && m_stall < (1 << CW) - 1) m_stall++;
      if (flush) m_valid = 0;
      else if (in_valid && adv && !haz) begin m_valid = 1; m_b = ref_decode(instr); end
      else if (adv) m_valid = 0;
    end
  end

  always @(posedge clk) if (!rst && out_valid && out_ready) d_xfer++;

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready),
        32'(!rst && (!m_valid || out_ready) && !m_hazard() && !flush));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("stall_count", 32'(stall_count), m_stall);
    if (m_valid) begin
      chk("imm_ext", imm_ext, m_b.imm);
      chk("alu_opcode", 32'(alu_opcode), 32'(m_b.alu));
      chk("ctrl{ld,st,we,ill}", {28'd0, is_load, is_store, write_en, illegal},
          {28'd0, m_b.ld, m_b.st, m_b.we, m_b.ill});
      chk("regs{rd,rs1,rs2}", {17'd0, rd, rs1, rs2}, {17'd0, m_b.rd, m_b.rs1, m_b.rs2});
    end
  end

  task automatic cyc(input logic v, input logic [31:0] w, input logic f, input logic r);
    in_valid = v; instr = w; flush = f; out_ready = r;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; in_valid = 1; instr = I_LW; flush = 0; out_ready = 1;
    #1 chk("lit reset in_ready", 32'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("lit reset out_valid", 32'(out_valid), 0);
    chk("lit reset bundle", {imm_ext ^ 32'd0} | {28'd0, alu_opcode} |
        {17'd0, rd, rs1, rs2} | {28'd0, is_load, is_store, write_en, illegal}, 0);
    chk("lit reset stall", 32'(stall_count), 0);
    rst = 0;

    cyc(1, I_LW, 0, 1);
    chk("lit lw valid", 32'(out_valid), 1);
    chk("lit lw ld/we", {30'd0, is_load, write_en}, 32'd3);
    chk("lit lw alu", 32'(alu_opcode), 0);
    chk("lit lw imm", imm_ext, 32'hFFFF_FFFF);
    chk("lit lw rd/rs1", {22'd0, rd, rs1}, {22'd0, 5'd5, 5'd1});

    cyc(1, I_SUB, 0, 1);
    chk("lit sub alu", 32'(alu_opcode), 2);
    chk("lit sub ld/we", {30'd0, is_load, write_en}, 32'd1);
    chk("lit sub imm/rd", imm_ext | 32'(rd), 32'd3);

    // load-use: exactly one bubble
    cyc(1, I_LW, 0, 1);
    in_valid = 1; instr = I_ADD;
    #1 chk("lit hazard in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("lit bubble out_valid", 32'(out_valid), 0);
    chk("lit bubble stall", 32'(stall_count), 1);
    chk("lit after bubble in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("lit add valid/rd", {26'd0, out_valid, rd}, {26'd0, 1'b1, 5'd6});

    // back-pressure
    cyc(1, I_OR, 0, 1);
    in_valid = 1; instr = I_XOR; out_ready = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("lit hold bundle", {19'd0, out_valid, write_en, alu_opcode, rd},
          {19'd0, 1'b1, 1'b1, 4'd4, 5'd7});
      chk("lit hold in_ready", 32'(in_ready), 0);
    end
    cyc(0, 32'd0, 0, 1);
    chk("lit single transfer", 32'(out_valid), 0);

    // flush cases
    in_valid = 1; instr = I_SUB; flush = 1;
    #1 chk("lit flush in_ready", 32'(in_ready), 0);
    cyc(1, I_SUB, 1, 1);
    chk("lit flush drop", 32'(out_valid), 0);
    cyc(1, I_SUB, 0, 0);
    cyc(0, 32'd0, 1, 0);
    chk("lit flush held", 32'(out_valid), 0);
    cyc(1, I_LW, 0, 1);
    cyc(1, I_ADD, 1, 1);
    chk("lit flush+hazard stall", {27'd0, out_valid, stall_count}, 32'd1);
    cyc(1, I_ADD, 0, 1);

    cyc(1, I_ILL, 0, 1);
    chk("lit illegal", {29'd0, out_valid, illegal, write_en}, 32'b110);
    chk("lit illegal imm", imm_ext, 0);

    cyc(1, I_SW, 0, 1);
    chk("lit sw imm/st", imm_ext | {31'd0, is_store}, 32'd9);
    cyc(1, I_BEQ, 0, 1);
    chk("lit beq imm", imm_ext, 32'hFFFF_FFFC);
    cyc(1, I_LUI, 0, 1);
    chk("lit lui imm/alu", imm_ext | 32'(alu_opcode), 32'h8000_000B);
    cyc(1, I_JAL, 0, 1);
    cyc(1, I_SRAI, 0, 1);
    chk("lit srai alu", 32'(alu_opcode), 8);
    cyc(1, I_ADDZ, 0, 1);
    chk("lit rd0 we", 32'(write_en), 0);
    cyc(1, 32'd0, 0, 1);
    chk("lit nop", {28'd0, out_valid, illegal, write_en, is_load}, 32'b1000);

    // store data dependency on load
    cyc(1, I_LW, 0, 1);
    cyc(1, I_SW5, 0, 1);
    cyc(1, I_SW5, 0, 1);
    chk("lit sw hazard stall", 32'(stall_count), 2);

    // saturate the counter
    repeat (16) begin
      cyc(1, I_LW, 0, 1);
      cyc(1, I_ADD, 0, 1);
      cyc(1, I_ADD, 0, 1);
    end
    chk("lit stall saturate", 32'(stall_count), 32'd15);

    repeat (3) cyc(0, 32'd0, 0, 1);
    chk("transfer count", d_xfer, m_xfer);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
